// File: rtl/divider.sv
// divider: multicycle 32-bit integer divider for the MIPS execute stage.
// Runs DIV/DIVU as a radix-2 restoring divider, one quotient bit per cycle, and
// produces the {HI, LO} = {remainder, quotient} pair. It also raises the
// divider stall towards the hazard unit while iterating.
//
// Ports:
//   clk        in   1   core clock, rising edge
//   rst        in   1   synchronous active-high reset
//   a          in  32   dividend (forwarded rs)
//   b          in  32   divisor (forwarded rt)
//   signed_div in   1   1 = DIV (two's complement), 0 = DIVU
//   start      in   1   level: a divide instruction occupies E
//   annul      in   1   flush of E, aborts any operation
//   hold       in   1   non-divider stall, E cannot advance
//   div_stall  out  1   stall request to the hazard unit (div_stallE)
//   ready      out  1   result valid for the instruction in E
//   result     out 64   {remainder (HI), quotient (LO)}
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        signed_div,
    input  logic        start,
    input  logic        annul,
    input  logic        hold,
    output logic        div_stall,
    output logic        ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} divState_t;

    divState_t   stateQ, stateD;
    logic [5:0]  cntQ, cntD;
    logic [31:0] remQ, remD;
    // Holds the dividend at the start; quotient bits shift in from the right.
    logic [31:0] dvdQ, dvdD;
    logic [31:0] divisorQ, divisorD;
    logic        signQuoQ, signQuoD;
    logic        signRemQ, signRemD;

    logic [31:0] absA, absB;
    logic [32:0] remShift;
    logic [32:0] trial;
    logic        qBit;
    logic [31:0] quoFinal, remFinal;

    // Operand magnitudes; -0x80000000 wraps to itself, which is the correct
    // unsigned magnitude.
    assign absA = (signed_div && a[31]) ? (~a + 32'd1) : a;
    assign absB = (signed_div && b[31]) ? (~b + 32'd1) : b;

    // One restoring step. Since rem < divisor is invariant, the shifted
    // remainder fits 33 bits and trial[32] is a clean borrow/sign bit.
    assign remShift = {remQ, dvdQ[31]};
    assign trial    = remShift - {1'b0, divisorQ};
    assign qBit     = ~trial[32];

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        remD     = remQ;
        dvdD     = dvdQ;
        divisorD = divisorQ;
        signQuoD = signQuoQ;
        signRemD = signRemQ;

        unique case (stateQ)
            StIdle: begin
                if (start && !annul) begin
                    dvdD     = absA;
                    divisorD = absB;
                    signQuoD = signed_div & (a[31] ^ b[31]);
                    signRemD = signed_div & a[31];
                    remD     = 32'd0;
                    cntD     = 6'd0;
                    stateD   = StBusy;
                end
            end
            StBusy: begin
                remD = qBit ? trial[31:0] : remShift[31:0];
                dvdD = {dvdQ[30:0], qBit};
                cntD = cntQ + 6'd1;
                if (cntQ == 6'd31) begin
                    stateD = StDone;
                end
            end
            StDone: begin
                if (!hold) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase

        // A flush of E outranks start and hold in every state.
        if (annul) begin
            stateD = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            cntQ     <= 6'd0;
            remQ     <= 32'd0;
            dvdQ     <= 32'd0;
            divisorQ <= 32'd0;
            signQuoQ <= 1'b0;
            signRemQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            remQ     <= remD;
            dvdQ     <= dvdD;
            divisorQ <= divisorD;
            signQuoQ <= signQuoD;
            signRemQ <= signRemD;
        end
    end

    // Sign correction is applied combinationally while in DONE.
    assign quoFinal = signQuoQ ? (~dvdQ + 32'd1) : dvdQ;
    assign remFinal = signRemQ ? (~remQ + 32'd1) : remQ;

    assign ready     = (stateQ == StDone);
    assign result    = ready ? {remFinal, quoFinal} : 64'd0;
    assign div_stall = ((stateQ == StIdle) && start && !annul) || (stateQ == StBusy);

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider.
module tb_divider;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_div;
    logic        start;
    logic        annul;
    logic        hold;
    logic        div_stall;
    logic        ready;
    logic [63:0] result;

    int nCompared;
    int nMismatched;

    divider dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .signed_div(signed_div),
        .start     (start),
        .annul     (annul),
        .hold      (hold),
        .div_stall (div_stall),
        .ready     (ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one divide starting in the current cycle (cycle 0). holdBusy drives
    // hold during the iteration; holdCycles keeps hold high from cycle 33 on.
    task automatic runDiv(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sg, input logic holdBusy, input int holdCycles,
                          input logic [63:0] exp);
        int stallCycles;
        a          = av;
        b          = bv;
        signed_div = sg;
        start      = 1'b1;
        hold       = holdBusy;
        #1;
        check({tag, "_ready_c0"}, {63'd0, ready}, 64'd0);
        stallCycles = 0;
        while (div_stall && stallCycles < 100) begin
            stallCycles++;
            tick();
        end
        check({tag, "_stall_cycles"}, 64'(stallCycles), 64'd33);
        for (int i = 0; i <= holdCycles; i++) begin
            check({tag, "_ready"}, {63'd0, ready}, 64'd1);
            check({tag, "_result"}, result, exp);
            check({tag, "_stall_done"}, {63'd0, div_stall}, 64'd0);
            hold = (i < holdCycles);
            tick();
        end
        start = 1'b0;
        hold  = 1'b0;
        #1;
        check({tag, "_ready_after"}, {63'd0, ready}, 64'd0);
        check({tag, "_stall_after"}, {63'd0, div_stall}, 64'd0);
    endtask

    initial begin
        int readySeen;
        nCompared   = 0;
        nMismatched = 0;
        rst         = 1'b1;
        a           = 32'd0;
        b           = 32'd0;
        signed_div  = 1'b0;
        start       = 1'b0;
        annul       = 1'b0;
        hold        = 1'b0;
        tick();
        tick();
        check("reset_stall", {63'd0, div_stall}, 64'd0);
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;
        tick();

        // annul outranks start in IDLE
        a     = 32'd10;
        b     = 32'd2;
        start = 1'b1;
        annul = 1'b1;
        #1;
        check("annul_over_start", {63'd0, div_stall}, 64'd0);
        tick();
        start = 1'b0;
        annul = 1'b0;
        #1;
        check("annul_idle_ready", {63'd0, ready}, 64'd0);
        check("annul_idle_stall", {63'd0, div_stall}, 64'd0);

        runDiv("udiv_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 0, {32'h2, 32'hE});
        // hold during BUSY must not slow the iteration
        runDiv("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        runDiv("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, {32'h1, 32'hFFFF_FFFD});
        runDiv("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0,
               {32'h0, 32'h8000_0000});
        runDiv("udiv_5_0", 32'd5, 32'd0, 1'b0, 1'b0, 0, {32'h5, 32'hFFFF_FFFF});
        runDiv("udiv_big", 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 0, {32'h0, 32'h5555_5555});

        // annul at BUSY cycle 10
        a          = 32'd1000;
        b          = 32'd3;
        signed_div = 1'b0;
        start      = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) tick();
        annul = 1'b1;
        #1;
        check("annul_busy_stall", {63'd0, div_stall}, 64'd1);
        tick();
        start = 1'b0;
        annul = 1'b0;
        #1;
        check("annul_next_stall", {63'd0, div_stall}, 64'd0);
        check("annul_next_ready", {63'd0, ready}, 64'd0);
        readySeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready || div_stall) readySeen++;
            tick();
        end
        check("annul_no_result", 64'(readySeen), 64'd0);
        runDiv("udiv_9_3", 32'd9, 32'd3, 1'b0, 1'b0, 0, {32'h0, 32'h3});

        // hold for 4 cycles from cycle 33: DONE lasts 5 cycles
        runDiv("udiv_hold", 32'd1000, 32'd7, 1'b0, 1'b0, 4, {32'h6, 32'h8E});

        // synchronous reset mid-BUSY
        a          = 32'h1234_5678;
        b          = 32'd3;
        signed_div = 1'b0;
        start      = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("rst_busy_stall", {63'd0, div_stall}, 64'd0);
        check("rst_busy_ready", {63'd0, ready}, 64'd0);
        check("rst_busy_result", result, 64'd0);
        tick();
        runDiv("udiv_ffff_10", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 0, {32'hF, 32'h0FFF_FFFF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
